shift_register_universal: RTL and testbench
===========================================

# shift_register_universal

Parametrised universal shift register with variable shift amount, rotate and arithmetic modes, plus an optional self-timed serialiser.

- Operating modes: load, logical, rotate and arithmetic shifts by 0..N-1 bits in one cycle.
- Serialiser (when compiled in): shifts a loaded word out MSB-first while capturing a serial input word, so one transfer does parallel-to-serial and serial-to-parallel at once.
- Placement: between parallel datapaths and single-wire links (UART/SPI-style framers) in the design examples.

## Interface

Parameters:
- N, default 8: register width in bits; N >= 2.
- AW, default $clog2(N): width of the shift-amount input; derived, do not override.

Ports:
- clk, input, 1: single clock; all state updates on rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- ctrl, input, 3: operation select; see Operation.
- amt, input, AW: shift/rotate amount, 0..N-1.
- data, input, N: parallel load value.
- ser_in, input, 1: serial input bit, also the fill bit for logical shifts.
- start, input, 1: request a serial transfer (serialiser builds only).
- q_reg, output, N: register contents.
- ser_out, output, 1: always q_reg[N-1].
- busy, output, 1: serial transfer in progress.
- done, output, 1: one-cycle pulse when a transfer completes.

## Operation

The ctrl encodings below apply only when the FSM is in IDLE:
- 0: hold.
- 1: logical right by amt; vacated MSBs filled with ser_in.
- 2: logical left by amt; vacated LSBs filled with ser_in.
- 3: load data.
- 4: rotate right by amt.
- 5: rotate left by amt.
- 6: arithmetic right by amt; vacated MSBs filled with old q_reg[N-1].
- 7: clear to 0.

Shift rules:
- amt = 0 behaves as hold for codes 1, 2, 4, 5 and 6.
- amt values >= N (non-power-of-2 N) are taken modulo N for rotates.
- amt values >= N for logical/arithmetic shifts produce all fill bits.

Serialiser FSM states: IDLE, SHIFT, DONE.
- IDLE -> SHIFT when start = 1:
  - q_reg <= data, and ctrl is ignored that cycle (start has priority over ctrl).
  - the bit counter is cleared.
- SHIFT:
  - busy = 1 and ctrl is ignored.
  - each cycle, q_reg <= {q_reg[N-2:0], ser_in} and the counter increments.
  - after N shifts the FSM moves to DONE.
- DONE:
  - done = 1 and busy = 0; register holds; ctrl and start are ignored.
  - next state is IDLE.
- start while busy or in DONE is ignored; it does not queue.

Reset:
- Reset (any time, including mid-transfer) forces q_reg = 0, ser_out = 0, busy = 0, done = 0, FSM = IDLE, counter = 0.
- The aborted transfer is lost.

## Timing

- All ctrl operations take effect at the first rising edge after they are presented; latency is 1 cycle and there are no bubbles between consecutive operations.
- Serial transfer, with start sampled high at edge k:
  - edge k: q_reg = data; ser_out = data[N-1] during cycle k..k+1; busy rises after edge k.
  - edges k+1..k+N: N left shifts; bit data[N-1-i] is on ser_out during the cycle after edge k+i, for i = 0..N-1.
  - ser_in is sampled at each of edges k+1..k+N; the first-sampled bit ends in q_reg[N-1].
  - after edge k+N: busy = 0, done = 1 for exactly one cycle.
  - after edge k+N+1: done = 0 and the FSM is in IDLE. The earliest next start is sampled at edge k+N+2.
- Transfer throughput is therefore one N-bit word per N+2 cycles.

## Configuration

- SHIFT_REGISTER_UNIVERSAL_SERIALIZER_EN defined: the FSM, bit counter, busy, done and start handling are compiled in, as described above.
- Macro undefined:
  - start is ignored; busy and done are tied to 0.
  - ctrl is always honoured; ser_out still equals q_reg[N-1].
  - no counter or FSM flops are present.

## Test plan

- Reset, then load: reset_n low with random inputs -> q_reg = 0x00. Release, ctrl=3, data=0xA5 -> q_reg = 0xA5 after one edge.
- Shifts, N=8, q_reg=0x96:
  - ctrl=1, amt=3, ser_in=1 -> 0xF2.
  - ctrl=2, amt=3, ser_in=0 -> 0xB0 (from 0x96).
  - ctrl=6, amt=2 -> 0xE5 (from 0x96).
  - ctrl=0 -> 0x96 held.
- Rotates and boundaries, q_reg=0x81:
  - ctrl=4, amt=1 -> 0xC0.
  - ctrl=5, amt=7 -> 0xC0 (from 0x81).
  - amt=0 with any of codes 1, 2, 4, 5, 6 -> unchanged.
  - ctrl=7 -> 0x00.
- Serial transfer:
  - start=1, data=0xC3, ser_in stream 1,0,1,1,0,0,1,0 (first to last).
  - ser_out sequence must be 1,1,0,0,0,0,1,1; busy high 8 cycles.
  - done pulses exactly 1 cycle, after which q_reg = 0xB2.
  - ctrl=7 applied mid-transfer must have no effect.
- Ignored start and reset abort:
  - start re-asserted during SHIFT and DONE -> not accepted; next transfer begins only from IDLE.
  - reset_n pulsed low at shift 4 -> busy = 0, done never pulses, q_reg = 0, FSM in IDLE.
- Macro undefined build: start=1 with ctrl=4, amt=1, q_reg=0x01 -> q_reg = 0x80; busy = 0 and done = 0 throughout.

Source files
------------

// File: rtl/shift_register_universal.sv
// Universal N-bit shift register: load, logical/arithmetic shift, rotate by a variable amount.
// Optional self-timed serialiser compiled in with SHIFT_REGISTER_UNIVERSAL_SERIALIZER_EN.
module shift_register_universal #(
   parameter int unsigned N  = 8,
   parameter int unsigned AW = $clog2(N)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [2:0]    ctrl,
   input  logic [AW-1:0] amt,
   input  logic [N-1:0]  data,
   input  logic          ser_in,
   input  logic          start,
   output logic [N-1:0]  q_reg,
   output logic          ser_out,
   output logic          busy,
   output logic          done
);

   logic [N-1:0]   op_q_c;
   logic [2*N-1:0] wide_c;
   logic           amt_ge_n_c;
   logic [AW-1:0]  rot_amt_c;
   logic           fill_c;

   // Parallel operation result; out-of-range amounts saturate shifts and wrap rotates
   always_comb begin
      amt_ge_n_c = (32'(amt) >= N);
      rot_amt_c  = amt_ge_n_c ? AW'(32'(amt) - N) : amt;
      wide_c     = '0;
      fill_c     = ser_in;
      op_q_c     = q_reg;
      case (ctrl)
         3'd1, 3'd6: begin
            fill_c = (ctrl == 3'd6) ? q_reg[N-1] : ser_in;
            wide_c = {{N{fill_c}}, q_reg} >> amt;
            op_q_c = amt_ge_n_c ? {N{fill_c}} : wide_c[N-1:0];
         end
         3'd2: begin
            wide_c = {q_reg, {N{ser_in}}} << amt;
            op_q_c = amt_ge_n_c ? {N{ser_in}} : wide_c[2*N-1:N];
         end
         3'd3: op_q_c = data;
         3'd4: begin
            wide_c = {q_reg, q_reg} >> rot_amt_c;
            op_q_c = wide_c[N-1:0];
         end
         3'd5: begin
            wide_c = {q_reg, q_reg} << rot_amt_c;
            op_q_c = wide_c[2*N-1:N];
         end
         3'd7:    op_q_c = '0;
         default: op_q_c = q_reg;
      endcase
   end

   assign ser_out = q_reg[N-1];

`ifdef SHIFT_REGISTER_UNIVERSAL_SERIALIZER_EN
   localparam int unsigned CW = $clog2(N);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t        state, state_nxt_c;
   logic [CW-1:0] cnt, cnt_nxt_c;
   logic [N-1:0]  q_nxt_c;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt_c;
   end

   always_comb begin
      state_nxt_c = state;
      case (state)
         S_IDLE:  if (start) state_nxt_c = S_SHIFT;
         S_SHIFT: if (cnt == CW'(N - 1)) state_nxt_c = S_DONE;
         S_DONE:  state_nxt_c = S_IDLE;
         default: state_nxt_c = S_IDLE;
      endcase
   end

   // Start beats ctrl in IDLE; SHIFT and DONE ignore ctrl entirely
   always_comb begin
      q_nxt_c   = q_reg;
      cnt_nxt_c = cnt;
      case (state)
         S_IDLE: begin
            if (start) begin
               q_nxt_c   = data;
               cnt_nxt_c = '0;
            end else begin
               q_nxt_c = op_q_c;
            end
         end
         S_SHIFT: begin
            q_nxt_c   = {q_reg[N-2:0], ser_in};
            cnt_nxt_c = cnt + CW'(1);
         end
         default: q_nxt_c = q_reg;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q_reg <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         q_reg <= q_nxt_c;
         cnt   <= cnt_nxt_c;
         busy  <= (state_nxt_c == S_SHIFT);
         done  <= (state_nxt_c == S_DONE);
      end
   end
`else
   logic unused_start;
   assign unused_start = start;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) q_reg <= '0;
      else          q_reg <= op_q_c;
   end

   assign busy = 1'b0;
   assign done = 1'b0;
`endif

endmodule

// File: tb/tb_shift_register_universal.sv
// Directed bench for shift_register_universal with a queue-based scoreboard of expected q_reg values.
module tb_shift_register_universal;
   localparam int unsigned N  = 8;
   localparam int unsigned AW = $clog2(N);

   logic          clk = 1'b0;
   logic          reset_n;
   logic [2:0]    ctrl;
   logic [AW-1:0] amt;
   logic [N-1:0]  data;
   logic          ser_in;
   logic          start;
   logic [N-1:0]  q_reg;
   logic          ser_out;
   logic          busy;
   logic          done;

   int n_cmp = 0;
   int n_err = 0;
   logic [N-1:0] exp_q[$];
   logic [N-1:0] model_q;
   logic [N-1:0] stream;

   always #5 clk = ~clk;

   shift_register_universal #(.N(N)) dut (
      .clk(clk), .reset_n(reset_n), .ctrl(ctrl), .amt(amt), .data(data),
      .ser_in(ser_in), .start(start), .q_reg(q_reg), .ser_out(ser_out),
      .busy(busy), .done(done)
   );

   task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge, then pop the next expected q_reg and compare it
   task automatic tick_check(input string tag);
      logic [N-1:0] e;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $error("FAIL %s: observed empty scoreboard expected entry", tag);
      end else begin
         e = exp_q.pop_front();
         chk(tag, q_reg, e);
         chk({tag, "_ser_out"}, N'(ser_out), N'(e[N-1]));
      end
   endtask

   task automatic op(input logic [2:0] c, input logic [AW-1:0] a, input logic [N-1:0] d,
                     input logic s, input logic [N-1:0] e, input string tag);
      ctrl   = c;
      amt    = a;
      data   = d;
      ser_in = s;
      exp_q.push_back(e);
      tick_check(tag);
   endtask

   initial begin
      reset_n = 1'b0;
      ctrl    = 3'($urandom);
      amt     = AW'($urandom);
      data    = N'($urandom);
      ser_in  = 1'($urandom);
      start   = 1'b0;
      @(posedge clk);
      #1;
      chk("reset_q", q_reg, '0);
      chk("reset_ser_out", N'(ser_out), '0);
      chk("reset_busy", N'(busy), '0);
      chk("reset_done", N'(done), '0);
      reset_n = 1'b1;

      op(3'd3, 0, 8'hA5, 0, 8'hA5, "load_a5");
      op(3'd3, 0, 8'h96, 0, 8'h96, "load_96");
      op(3'd1, 3, 8'h00, 1, 8'hF2, "lsr3_fill1");
      op(3'd3, 0, 8'h96, 0, 8'h96, "load_96b");
      op(3'd2, 3, 8'h00, 0, 8'hB0, "lsl3_fill0");
      op(3'd3, 0, 8'h96, 0, 8'h96, "load_96c");
      op(3'd6, 2, 8'h00, 0, 8'hE5, "asr2");
      op(3'd3, 0, 8'h96, 0, 8'h96, "load_96d");
      op(3'd0, 5, 8'h3C, 1, 8'h96, "hold");
      op(3'd2, 1, 8'h00, 1, 8'h2D, "lsl1_fill1");
      op(3'd6, 7, 8'h00, 0, 8'h00, "asr7_pos");

      op(3'd3, 0, 8'h81, 0, 8'h81, "load_81");
      op(3'd4, 1, 8'h00, 0, 8'hC0, "ror1");
      op(3'd3, 0, 8'h81, 0, 8'h81, "load_81b");
      op(3'd5, 7, 8'h00, 0, 8'hC0, "rol7");
      op(3'd3, 0, 8'h81, 0, 8'h81, "load_81c");
      op(3'd1, 0, 8'h00, 0, 8'h81, "amt0_lsr");
      op(3'd2, 0, 8'h00, 1, 8'h81, "amt0_lsl");
      op(3'd4, 0, 8'h00, 1, 8'h81, "amt0_ror");
      op(3'd5, 0, 8'h00, 0, 8'h81, "amt0_rol");
      op(3'd6, 0, 8'h00, 1, 8'h81, "amt0_asr");
      op(3'd6, 7, 8'h00, 0, 8'hFF, "asr7_neg");
      op(3'd7, 3, 8'h55, 1, 8'h00, "clear");

`ifdef SHIFT_REGISTER_UNIVERSAL_SERIALIZER_EN
      // Full transfer: start beats ctrl, SHIFT ignores ctrl and start
      stream = 8'b1011_0010;
      ctrl   = 3'd7;
      amt    = 0;
      data   = 8'hC3;
      start  = 1'b1;
      exp_q.push_back(8'hC3);
      tick_check("ser_load");
      chk("ser_busy_k", N'(busy), 1);
      chk("ser_done_k", N'(done), 0);
      model_q = 8'hC3;
      for (int i = 1; i <= 8; i++) begin
         ser_in  = stream[8-i];
         start   = (i == 2) || (i == 5);
         ctrl    = (i == 3) ? 3'd7 : 3'd3;
         data    = 8'h5A;
         model_q = {model_q[N-2:0], stream[8-i]};
         exp_q.push_back(model_q);
         tick_check("ser_shift");
         chk("ser_busy", N'(busy), (i < 8) ? 1 : 0);
         chk("ser_done", N'(done), (i == 8) ? 1 : 0);
      end
      chk("ser_final", q_reg, 8'hB2);
      start = 1'b1;
      ctrl  = 3'd7;
      exp_q.push_back(8'hB2);
      tick_check("done_hold");
      chk("done_pulse_end", N'(done), 0);
      chk("done_start_ignored", N'(busy), 0);
      start = 1'b0;
      op(3'd0, 0, 8'h00, 0, 8'hB2, "idle_hold");

      // Abort mid-transfer with reset
      data  = 8'h5A;
      start = 1'b1;
      exp_q.push_back(8'h5A);
      tick_check("abort_load");
      start   = 1'b0;
      model_q = 8'h5A;
      for (int i = 0; i < 4; i++) begin
         ser_in  = 1'b1;
         model_q = {model_q[N-2:0], 1'b1};
         exp_q.push_back(model_q);
         tick_check("abort_shift");
      end
      #2;
      reset_n = 1'b0;
      #1;
      chk("abort_q", q_reg, '0);
      chk("abort_busy", N'(busy), 0);
      chk("abort_done", N'(done), 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         op(3'd0, 0, 8'h00, 1, 8'h00, "post_abort_hold");
         chk("post_abort_busy", N'(busy), 0);
         chk("post_abort_done", N'(done), 0);
      end
      op(3'd3, 0, 8'h3C, 0, 8'h3C, "post_abort_load");
`else
      // Without the serialiser start is ignored and ctrl always applies
      op(3'd3, 0, 8'h01, 0, 8'h01, "load_01");
      start = 1'b1;
      op(3'd4, 1, 8'hFF, 0, 8'h80, "nostart_ror1");
      chk("nostart_busy", N'(busy), 0);
      chk("nostart_done", N'(done), 0);
      for (int i = 0; i < 10; i++) begin
         op(3'd0, 0, 8'hFF, 1, 8'h80, "nostart_hold");
         chk("nostart_busy_hold", N'(busy), 0);
         chk("nostart_done_hold", N'(done), 0);
      end
      start = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
